// File: rtl/wrr_rank_merge.sv
// Pairs parser descriptors with WRR engine ranks and feeds matched entries to the PIFO insert port.
// Latency: rank one cycle after the request gives ins_valid two cycles after acceptance; back-pressure via desc_ready = descriptor FIFO not full.
// Optional counters under `WRR_RANK_MERGE_STATS_EN (stat_ins_count, stat_stall_count).

module wrr_rank_merge_fifo #(
    parameter int W          = 32,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push,
    input  logic [W-1:0]          push_dat,
    input  logic                  pop,
    output logic [W-1:0]          head_dat,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [W-1:0]        mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (rstn && push) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_dat;
        end
    end

    assign head_dat = mem[rd_ptr[DEPTH_LOG2-1:0]];
    assign full     = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                      (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign count    = wr_ptr - rd_ptr;
endmodule

module wrr_rank_merge #(
    parameter int CLASS_WIDTH         = 8,
    parameter int WEIGHT_WIDTH        = 16,
    parameter int DESC_WIDTH          = 32,
    parameter int RESULT_WIDTH        = 32,
    parameter int PIFO_OVERFLOW_WIDTH = 1,
    parameter int PIFO_ROUND_WIDTH    = 17,
    parameter int PIFO_ADDR_WIDTH     = 12,
    parameter int DEPTH_LOG2          = 3
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           desc_valid,
    output logic                           desc_ready,
    input  logic [DESC_WIDTH-1:0]          desc_data,
    input  logic [CLASS_WIDTH-1:0]         desc_class_id,
    input  logic [WEIGHT_WIDTH-1:0]        desc_class_weight,
    output logic                           req_valid,
    output logic [CLASS_WIDTH-1:0]         req_class_id,
    output logic [WEIGHT_WIDTH-1:0]        req_class_weight,
    input  logic                           rank_valid,
    input  logic [RESULT_WIDTH-1:0]        rank_data,
    output logic                           ins_valid,
    input  logic                           ins_ready,
    output logic [RESULT_WIDTH-1:0]        ins_rank,
    output logic [DESC_WIDTH-1:0]          ins_desc,
    input  logic                           deq_valid,
    input  logic [RESULT_WIDTH-1:0]        deq_rank,
    output logic                           last_pifo_valid,
    output logic [PIFO_OVERFLOW_WIDTH-1:0] last_pifo_overflow,
    output logic [PIFO_ROUND_WIDTH-1:0]    last_pifo_round,
    output logic                           err_orphan_rank
`ifdef WRR_RANK_MERGE_STATS_EN
    ,
    output logic [31:0]                    stat_ins_count,
    output logic [31:0]                    stat_stall_count
`endif
);
    localparam int RND_LO = PIFO_ADDR_WIDTH;
    localparam int OVF_LO = PIFO_ADDR_WIDTH + PIFO_ROUND_WIDTH;

    logic                    d_full;
    logic                    d_empty;
    logic [DEPTH_LOG2:0]     d_count;
    logic [DESC_WIDTH-1:0]   d_head;
    logic                    k_full;
    logic                    k_empty;
    logic [DEPTH_LOG2:0]     k_count;
    logic [RESULT_WIDTH-1:0] k_head;
    logic                    k_push;
    logic                    orphan;
    logic                    ins_pop;

    assign desc_ready       = ~d_full;
    assign req_valid        = desc_valid & desc_ready;
    assign req_class_id     = desc_class_id;
    assign req_class_weight = desc_class_weight;

    // A rank is only legal while some accepted descriptor still lacks one.
    assign orphan  = rank_valid & (k_count == d_count);
    assign k_push  = rank_valid & ~orphan & ~k_full;

    assign ins_valid = ~d_empty & ~k_empty;
    assign ins_pop   = ins_valid & ins_ready;
    assign ins_rank  = ins_valid ? k_head : '0;
    assign ins_desc  = ins_valid ? d_head : '0;

    wrr_rank_merge_fifo #(
        .W          (DESC_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_desc_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (req_valid),
        .push_dat (desc_data),
        .pop      (ins_pop),
        .head_dat (d_head),
        .full     (d_full),
        .empty    (d_empty),
        .count    (d_count)
    );

    wrr_rank_merge_fifo #(
        .W          (RESULT_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_rank_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (k_push),
        .push_dat (rank_data),
        .pop      (ins_pop),
        .head_dat (k_head),
        .full     (k_full),
        .empty    (k_empty),
        .count    (k_count)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_orphan_rank <= 1'b0;
        end else if (orphan) begin
            err_orphan_rank <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_pifo_valid    <= 1'b0;
            last_pifo_overflow <= '0;
            last_pifo_round    <= '0;
        end else if (deq_valid) begin
            last_pifo_valid    <= 1'b1;
            last_pifo_overflow <= deq_rank[OVF_LO +: PIFO_OVERFLOW_WIDTH];
            last_pifo_round    <= deq_rank[RND_LO +: PIFO_ROUND_WIDTH];
        end
    end

`ifdef WRR_RANK_MERGE_STATS_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stat_ins_count   <= '0;
            stat_stall_count <= '0;
        end else begin
            if (ins_pop && (stat_ins_count != '1)) begin
                stat_ins_count <= stat_ins_count + 1'b1;
            end
            if (desc_valid && !desc_ready && (stat_stall_count != '1)) begin
                stat_stall_count <= stat_stall_count + 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_wrr_rank_merge.sv
// Directed bench for wrr_rank_merge: vector table for the single-entry, dequeue and orphan paths,
// plus hand sequences for fill/drain, pointer wrap, mid-run reset and (if enabled) statistics.
module tb_wrr_rank_merge;
    logic        clk = 1'b0;
    logic        rstn;
    logic        desc_valid;
    logic        desc_ready;
    logic [31:0] desc_data;
    logic [7:0]  desc_class_id;
    logic [15:0] desc_class_weight;
    logic        req_valid;
    logic [7:0]  req_class_id;
    logic [15:0] req_class_weight;
    logic        rank_valid;
    logic [31:0] rank_data;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] ins_rank;
    logic [31:0] ins_desc;
    logic        deq_valid;
    logic [31:0] deq_rank;
    logic        last_pifo_valid;
    logic [0:0]  last_pifo_overflow;
    logic [16:0] last_pifo_round;
    logic        err_orphan_rank;
`ifdef WRR_RANK_MERGE_STATS_EN
    logic [31:0] stat_ins_count;
    logic [31:0] stat_stall_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wrr_rank_merge dut (
        .clk                (clk),
        .rstn               (rstn),
        .desc_valid         (desc_valid),
        .desc_ready         (desc_ready),
        .desc_data          (desc_data),
        .desc_class_id      (desc_class_id),
        .desc_class_weight  (desc_class_weight),
        .req_valid          (req_valid),
        .req_class_id       (req_class_id),
        .req_class_weight   (req_class_weight),
        .rank_valid         (rank_valid),
        .rank_data          (rank_data),
        .ins_valid          (ins_valid),
        .ins_ready          (ins_ready),
        .ins_rank           (ins_rank),
        .ins_desc           (ins_desc),
        .deq_valid          (deq_valid),
        .deq_rank           (deq_rank),
        .last_pifo_valid    (last_pifo_valid),
        .last_pifo_overflow (last_pifo_overflow),
        .last_pifo_round    (last_pifo_round),
        .err_orphan_rank    (err_orphan_rank)
`ifdef WRR_RANK_MERGE_STATS_EN
        ,
        .stat_ins_count     (stat_ins_count),
        .stat_stall_count   (stat_stall_count)
`endif
    );

    typedef struct {
        logic        dv;
        logic [31:0] dd;
        logic [7:0]  cid;
        logic [15:0] wgt;
        logic        rv;
        logic [31:0] rd;
        logic        ir;
        logic        qv;
        logic [31:0] qr;
        logic        e_drdy;
        logic        e_req;
        logic        e_iv;
        logic [31:0] e_ir;
        logic [31:0] e_id;
        logic        e_lpv;
        logic        e_ovf;
        logic [16:0] e_rnd;
        logic        e_err;
    } vec_t;

    localparam int NV = 17;
    vec_t tv [NV];

    function automatic vec_t mk(input logic dv, input logic [31:0] dd, input logic [7:0] cid,
                                input logic rv, input logic [31:0] rd, input logic ir,
                                input logic qv, input logic [31:0] qr,
                                input logic e_drdy, input logic e_req, input logic e_iv,
                                input logic [31:0] e_ir, input logic [31:0] e_id,
                                input logic e_lpv, input logic e_ovf, input logic [16:0] e_rnd,
                                input logic e_err);
        vec_t v;
        v.dv = dv; v.dd = dd; v.cid = cid; v.wgt = {cid, 8'h5A};
        v.rv = rv; v.rd = rd; v.ir = ir; v.qv = qv; v.qr = qr;
        v.e_drdy = e_drdy; v.e_req = e_req; v.e_iv = e_iv; v.e_ir = e_ir; v.e_id = e_id;
        v.e_lpv = e_lpv; v.e_ovf = e_ovf; v.e_rnd = e_rnd; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        desc_valid = 1'b0; desc_data = '0; desc_class_id = '0; desc_class_weight = '0;
        rank_valid = 1'b0; rank_data = '0; ins_ready = 1'b0; deq_valid = 1'b0; deq_rank = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rstn = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_desc_ready"}, 32'(desc_ready), 32'd1);
        chk({tag, "_ins_valid"}, 32'(ins_valid), 32'd0);
        chk({tag, "_ins_rank"}, ins_rank, 32'd0);
        chk({tag, "_ins_desc"}, ins_desc, 32'd0);
        chk({tag, "_lpv"}, 32'(last_pifo_valid), 32'd0);
        chk({tag, "_ovf"}, 32'(last_pifo_overflow), 32'd0);
        chk({tag, "_round"}, 32'(last_pifo_round), 32'd0);
        chk({tag, "_err"}, 32'(err_orphan_rank), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int recv;
        logic        prev_req;
        logic [31:0] prev_idx;

        rstn = 1'b0;
        idle_inputs();

        // Per-cycle vectors; expectations are the outputs seen before the capturing edge.
        tv[0]  = mk(1, 32'hA5A5_0001, 8'd3, 0, 32'h0,         1, 0, 32'h0,         1, 1, 0, 32'h0,         32'h0,         0, 0, 17'h0,  0);
        tv[1]  = mk(0, 32'h0,         8'd3, 1, 32'h4000_5000, 1, 0, 32'h0,         1, 0, 0, 32'h0,         32'h0,         0, 0, 17'h0,  0);
        tv[2]  = mk(0, 32'h0,         8'd0, 0, 32'h0,         1, 0, 32'h0,         1, 0, 1, 32'h4000_5000, 32'hA5A5_0001, 0, 0, 17'h0,  0);
        tv[3]  = mk(0, 32'h0,         8'd1, 0, 32'h0,         1, 1, 32'h6001_F000, 1, 0, 0, 32'h0,         32'h0,         0, 0, 17'h0,  0);
        tv[4]  = mk(0, 32'h0,         8'd2, 0, 32'h0,         1, 0, 32'h0,         1, 0, 0, 32'h0,         32'h0,         1, 1, 17'h1F, 0);
        tv[5]  = mk(0, 32'h0,         8'd4, 0, 32'h0,         1, 1, 32'h4000_3000, 1, 0, 0, 32'h0,         32'h0,         1, 1, 17'h1F, 0);
        tv[6]  = mk(0, 32'h0,         8'd5, 0, 32'h0,         1, 0, 32'h0,         1, 0, 0, 32'h0,         32'h0,         1, 0, 17'h3,  0);
        tv[7]  = mk(0, 32'h0,         8'd6, 0, 32'h0,         1, 0, 32'h0,         1, 0, 0, 32'h0,         32'h0,         1, 0, 17'h3,  0);
        tv[8]  = mk(0, 32'h0,         8'd0, 1, 32'h4000_0001, 1, 0, 32'h0,         1, 0, 0, 32'h0,         32'h0,         1, 0, 17'h3,  0);
        tv[9]  = mk(0, 32'h0,         8'd0, 0, 32'h0,         1, 0, 32'h0,         1, 0, 0, 32'h0,         32'h0,         1, 0, 17'h3,  1);
        tv[10] = mk(1, 32'h0000_0011, 8'd7, 0, 32'h0,         0, 0, 32'h0,         1, 1, 0, 32'h0,         32'h0,         1, 0, 17'h3,  1);
        tv[11] = mk(1, 32'h0000_0022, 8'd8, 1, 32'h4000_1011, 0, 0, 32'h0,         1, 1, 0, 32'h0,         32'h0,         1, 0, 17'h3,  1);
        tv[12] = mk(0, 32'h0,         8'd0, 1, 32'h4000_1022, 0, 0, 32'h0,         1, 0, 1, 32'h4000_1011, 32'h11,        1, 0, 17'h3,  1);
        tv[13] = mk(0, 32'h0,         8'd0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 1, 32'h4000_1011, 32'h11,        1, 0, 17'h3,  1);
        tv[14] = mk(0, 32'h0,         8'd0, 0, 32'h0,         1, 0, 32'h0,         1, 0, 1, 32'h4000_1011, 32'h11,        1, 0, 17'h3,  1);
        tv[15] = mk(0, 32'h0,         8'd0, 0, 32'h0,         1, 0, 32'h0,         1, 0, 1, 32'h4000_1022, 32'h22,        1, 0, 17'h3,  1);
        tv[16] = mk(0, 32'h0,         8'd0, 0, 32'h0,         1, 0, 32'h0,         1, 0, 0, 32'h0,         32'h0,         1, 0, 17'h3,  1);

        do_reset();
        @(negedge clk);
        chk_reset_state("rst0");

        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            desc_valid = tv[i].dv; desc_data = tv[i].dd;
            desc_class_id = tv[i].cid; desc_class_weight = tv[i].wgt;
            rank_valid = tv[i].rv; rank_data = tv[i].rd; ins_ready = tv[i].ir;
            deq_valid = tv[i].qv; deq_rank = tv[i].qr;
            @(negedge clk);
            chk($sformatf("v%0d_desc_ready", i), 32'(desc_ready), 32'(tv[i].e_drdy));
            chk($sformatf("v%0d_req_valid", i), 32'(req_valid), 32'(tv[i].e_req));
            chk($sformatf("v%0d_req_class", i), 32'(req_class_id), 32'(tv[i].cid));
            chk($sformatf("v%0d_req_weight", i), 32'(req_class_weight), 32'(tv[i].wgt));
            chk($sformatf("v%0d_ins_valid", i), 32'(ins_valid), 32'(tv[i].e_iv));
            chk($sformatf("v%0d_ins_rank", i), ins_rank, tv[i].e_ir);
            chk($sformatf("v%0d_ins_desc", i), ins_desc, tv[i].e_id);
            chk($sformatf("v%0d_lpv", i), 32'(last_pifo_valid), 32'(tv[i].e_lpv));
            chk($sformatf("v%0d_ovf", i), 32'(last_pifo_overflow), 32'(tv[i].e_ovf));
            chk($sformatf("v%0d_round", i), 32'(last_pifo_round), 32'(tv[i].e_rnd));
            chk($sformatf("v%0d_err", i), 32'(err_orphan_rank), 32'(tv[i].e_err));
        end

        // Fill to capacity with the PIFO stalled, then drain.
        do_reset();
        @(negedge clk);
        chk("fill_err_cleared", 32'(err_orphan_rank), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            desc_valid = 1'b1;
            desc_data  = (i < 8) ? 32'h100 + 32'(i) : 32'h999;
            rank_valid = (i >= 1) && (i <= 8);
            rank_data  = 32'h4000_0000 + 32'(i - 1);
            ins_ready  = 1'b0;
            @(negedge clk);
            chk($sformatf("fill%0d_desc_ready", i), 32'(desc_ready), (i < 8) ? 32'd1 : 32'd0);
            chk($sformatf("fill%0d_req_valid", i), 32'(req_valid), (i < 8) ? 32'd1 : 32'd0);
        end
        for (int j = 0; j < 8; j++) begin
            @(posedge clk); #1;
            desc_valid = 1'b0; rank_valid = 1'b0; ins_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("drain%0d_ins_valid", j), 32'(ins_valid), 32'd1);
            chk($sformatf("drain%0d_desc", j), ins_desc, 32'h100 + 32'(j));
            chk($sformatf("drain%0d_rank", j), ins_rank, 32'h4000_0000 + 32'(j));
            chk($sformatf("drain%0d_desc_ready", j), 32'(desc_ready), (j == 0) ? 32'd0 : 32'd1);
        end
        @(posedge clk); #1;
        ins_ready = 1'b0;
        @(negedge clk);
        chk("drain_empty", 32'(ins_valid), 32'd0);
        chk("drain_err", 32'(err_orphan_rank), 32'd0);

        // Streaming with toggling ins_ready; one-cycle engine model, pointers wrap several times.
        sent = 0; recv = 0; prev_req = 1'b0; prev_idx = '0;
        for (int c = 0; c < 400 && recv < 40; c++) begin
            @(posedge clk); #1;
            desc_valid = (sent < 40);
            desc_data  = 32'hD000_0000 + 32'(sent);
            rank_valid = prev_req;
            rank_data  = 32'h4000_0000 + prev_idx;
            ins_ready  = (c % 2 == 1);
            @(negedge clk);
            prev_req = req_valid;
            prev_idx = 32'(sent);
            if (req_valid) sent++;
            if (ins_valid && ins_ready) begin
                chk($sformatf("wrap%0d_desc", recv), ins_desc, 32'hD000_0000 + 32'(recv));
                chk($sformatf("wrap%0d_rank", recv), ins_rank, 32'h4000_0000 + 32'(recv));
                recv++;
            end
        end
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("wrap_count", 32'(recv), 32'd40);
        chk("wrap_err", 32'(err_orphan_rank), 32'd0);
        chk("wrap_empty", 32'(ins_valid), 32'd0);

        // Reset with four entries queued and a dequeue recorded.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            desc_valid = (i < 4);
            desc_data  = 32'h700 + 32'(i);
            rank_valid = (i >= 1);
            rank_data  = 32'h4000_0700 + 32'(i - 1);
            ins_ready  = 1'b0;
            deq_valid  = (i == 0);
            deq_rank   = 32'h6001_F000;
            @(negedge clk);
        end
        chk("preq_ins_valid", 32'(ins_valid), 32'd1);
        chk("preq_lpv", 32'(last_pifo_valid), 32'd1);
        @(posedge clk); #1;
        rstn = 1'b0;
        idle_inputs();
        @(posedge clk); #1;
        rstn = 1'b1;
        rank_valid = 1'b1;
        rank_data  = 32'h4000_0055;
        @(negedge clk);
        chk_reset_state("midrst");
        @(posedge clk); #1;
        rank_valid = 1'b0;
        @(negedge clk);
        chk("inflight_err", 32'(err_orphan_rank), 32'd1);
        chk("inflight_ins_valid", 32'(ins_valid), 32'd0);

`ifdef WRR_RANK_MERGE_STATS_EN
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            desc_valid = (i < 5);
            desc_data  = 32'h800 + 32'(i);
            rank_valid = (i >= 1);
            rank_data  = 32'h4000_0800 + 32'(i - 1);
            ins_ready  = 1'b1;
        end
        @(posedge clk); #1;
        idle_inputs();
        ins_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("stat_ins_count", stat_ins_count, 32'd5);
        chk("stat_stall_count", stat_stall_count, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/wrr_rank_merge.md
# wrr_rank_merge

Pairs packet descriptors with the ranks returned by the WRR rank engine and presents matched {rank, descriptor} entries to the PIFO insert port. It sits between the parser and the PIFO, alongside the rank engine. It also issues the engine's request strobe and tracks PIFO dequeues to drive the engine's `last_pifo_*` inputs.

## Interface
- `CLASS_WIDTH`, 8: class id width.
- `WEIGHT_WIDTH`, 16: class weight width.
- `DESC_WIDTH`, 32: opaque descriptor width.
- `RESULT_WIDTH`, 32: rank width.
- `PIFO_OVERFLOW_WIDTH`, 1: overflow field width.
- `PIFO_ROUND_WIDTH`, 17: round field width.
- `PIFO_ADDR_WIDTH`, 12: address field width.
- `DEPTH_LOG2`, 3: each FIFO holds 2^DEPTH_LOG2 entries.

Ports:
- `clk`  in  1  clock.
- `rstn`  in  1  reset; synchronous, active-low.
- `desc_valid`  in  1  descriptor offered.
- `desc_ready`  out  1  descriptor accepted when high with `desc_valid`.
- `desc_data`  in  DESC_WIDTH  descriptor.
- `desc_class_id`  in  CLASS_WIDTH  class of the descriptor.
- `desc_class_weight`  in  WEIGHT_WIDTH  weight of the class.
- `req_valid`  out  1  engine request; equals `desc_valid & desc_ready` (combinational).
- `req_class_id`  out  CLASS_WIDTH  `desc_class_id` passthrough.
- `req_class_weight`  out  WEIGHT_WIDTH  `desc_class_weight` passthrough.
- `rank_valid`  in  1  engine response strobe.
- `rank_data`  in  RESULT_WIDTH  engine rank.
- `ins_valid`  out  1  merged entry available.
- `ins_ready`  in  1  PIFO accepts.
- `ins_rank`  out  RESULT_WIDTH  rank of the head entry.
- `ins_desc`  out  DESC_WIDTH  descriptor of the head entry.
- `deq_valid`  in  1  PIFO popped an entry.
- `deq_rank`  in  RESULT_WIDTH  rank of the popped entry.
- `last_pifo_valid`  out  1  a dequeue has been seen since reset.
- `last_pifo_overflow`  out  PIFO_OVERFLOW_WIDTH  overflow field of the last popped rank.
- `last_pifo_round`  out  PIFO_ROUND_WIDTH  round field of the last popped rank.
- `err_orphan_rank`  out  1  sticky; set when a rank arrives with no unmatched descriptor.

## Operation
- **Rank layout**, with A = PIFO_ADDR_WIDTH and R = PIFO_ROUND_WIDTH:
  - bits [A-1:0]: address.
  - bits [A+R-1:A]: round.
  - bits [A+R+O-1:A+R], O = PIFO_OVERFLOW_WIDTH: overflow.
  - next bit up: flag (always 1).
  - remaining upper bits: zero.
  - Defaults: round [28:12], overflow [29], flag [30], bit 31 = 0.
- **Descriptor FIFO (D):** pushed on `req_valid` with `desc_data`. `desc_ready` = D not full. A pop in the same cycle does not free a slot.
- **Rank FIFO (K):** pushed on `rank_valid` with `rank_data`. Its occupancy never exceeds D's.
  - If `rank_valid` arrives while count(K) == count(D), the push is dropped and `err_orphan_rank` sets.
  - `err_orphan_rank` clears only on reset.
- **Merge:**
  - `ins_valid` = D non-empty & K non-empty.
  - `ins_rank`/`ins_desc` = heads of K/D.
  - Both FIFOs pop on `ins_valid & ins_ready`.
- **Dequeue tracking:** on `deq_valid`, register the overflow and round fields of `deq_rank` and set `last_pifo_valid`. Values hold until the next `deq_valid`.
- **Pointers:** DEPTH_LOG2+1 bits, wrap modulo 2^(DEPTH_LOG2+1).
  - Full: MSBs differ and lower bits are equal.
  - Empty: pointers equal.
- **Simultaneous events:**
  - Push and pop on a non-empty, non-full FIFO leave its count unchanged.
  - `deq_valid` in the same cycle as an insert is independent of it.

## Timing
- Reset values:
  - `desc_ready` = 1 (D empty).
  - `ins_valid` = 0, `ins_rank` = 0, `ins_desc` = 0.
  - `last_pifo_valid` = 0, `last_pifo_overflow` = 0, `last_pifo_round` = 0.
  - `err_orphan_rank` = 0.
  - All pointers = 0.
- Reset mid-operation empties both FIFOs in one cycle. Ranks still in flight that arrive after reset set `err_orphan_rank`.
- Latency with a 1-cycle engine and `ins_ready` = 1:
  - descriptor accepted at cycle t;
  - rank arrives at t+1;
  - `ins_valid` high at t+2.
- `ins_rank`/`ins_desc` come from registered FIFO heads. They are stable while `ins_valid & ~ins_ready`.
- Throughput: one insert per cycle at steady state.
- `last_pifo_*` update one cycle after `deq_valid`.

## Configuration
- `WRR_RANK_MERGE_STATS_EN` defined:
  - adds output `stat_ins_count` (32 b): counts inserts;
  - adds output `stat_stall_count` (32 b): counts cycles with `desc_valid & ~desc_ready`.
  - Both counters reset to 0 and saturate at 2^32-1.
- Undefined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- Single descriptor (0xA5A5_0001, class 3), engine returns 0x4000_5000 at t+1 -> `ins_valid` at t+2 with `ins_rank`=0x4000_5000 and `ins_desc`=0xA5A5_0001.
- 8 descriptors with `ins_ready`=0 -> `desc_ready` falls after the 8th; 9th is held and `req_valid` stays 0. Then `ins_ready`=1 -> 8 entries drain in order, one per cycle, and `desc_ready` returns.
- `rank_valid` pulse with both FIFOs empty -> `err_orphan_rank`=1, `ins_valid` stays 0. Flag persists until `rstn`=0.
- `deq_valid` with `deq_rank`=0x6001_F000 -> next cycle: `last_pifo_valid`=1, `last_pifo_overflow`=1, `last_pifo_round`=0x1F. Holds until the next dequeue.
- Continuous descriptors with `ins_ready` toggling every cycle, pointers wrapping 3+ times -> no loss, no reordering, no error.
- `rstn` low with 4 entries queued -> next cycle all outputs at reset values. With `WRR_RANK_MERGE_STATS_EN`: 5 inserts -> `stat_ins_count`=5.
